bcd_7seg_scan_driver: RTL and testbench
=======================================

// Module: bcd_7seg_scan_driver
// PURPOSE
//  Time-multiplexed N-digit 7-segment display driver. Captures packed BCD digits and decimal
//  points, decodes each digit to segments, and scans one digit at a time with a programmable
//  refresh rate and an anti-ghosting blank interval. Sits between counter/ALU result logic and
//  the board's common-anode or common-cathode display pins.
// PARAMETERS
//  NUM_DIGITS       4     number of digits scanned, >=1
//  SCAN_DIV         1000  clk cycles per digit slot, >=2
//  BLANK_CYCLES     16    cycles at slot start with all digits off, 0..SCAN_DIV-1
//  HEX_MODE         0     1: codes A-F shown as A b C d E F; 0: codes A-F blanked
//  LZ_SUPPRESS      1     1: blank leading zeros
//  SEG_ACTIVE_LOW   0     1: invert seg_out and dp_out at the pins
//  DIG_ACTIVE_LOW   1     1: invert dig_sel at the pins
// PORTS
//  clk          in   1              rising-edge clock
//  rst_n        in   1              asynchronous active-low reset
//  enable       in   1              0: display dark, scan held
//  load         in   1              capture digits_in/dp_in this cycle
//  digits_in    in   4*NUM_DIGITS   packed BCD; [3:0] = digit 0 (rightmost)
//  dp_in        in   NUM_DIGITS     decimal point per digit
//  seg_out      out  7              segments {g,f,e,d,c,b,a}, bit0 = a
//  dp_out       out  1              decimal point of active digit
//  dig_sel      out  NUM_DIGITS     one-hot digit enable
//  frame_start  out  1              1-cycle pulse when digit 0 slot begins
// BEHAVIOUR
//  - Reset (async assert, sync release): prescaler=0, digit index=0, display and pending regs=0,
//    pending_valid=0; seg_out/dp_out/dig_sel inactive (all off after polarity), frame_start=0.
//  - Prescaler counts 0..SCAN_DIV-1 while enable=1; at SCAN_DIV-1 it wraps and the index
//    advances modulo NUM_DIGITS (NUM_DIGITS-1 -> 0 is the frame boundary).
//  - Double buffering: load writes pending reg, sets pending_valid. At a frame boundary with
//    pending_valid=1, pending -> display reg, pending_valid cleared. A load coinciding with the
//    boundary writes digits_in straight to display reg. Last load before a boundary wins.
//    While enable=0, pending transfers to display on the cycle after load.
//  - Decode (logical, active-high): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110
//    5=1101101 6=1111101 7=0000111 8=1111111 9=1101111; HEX_MODE=1: A=1110111 b=1111100
//    C=0111001 d=1011110 E=1111001 F=1110001; HEX_MODE=0: A-F -> 0000000.
//  - LZ_SUPPRESS: digit k (k>0) blanked if it and all digits above it are 0 and none of their
//    dp bits are set; digit 0 is never suppressed. A blanked digit shows segments 0000000 and
//    its dp still displays.
//  - Blank interval: prescaler < BLANK_CYCLES -> dig_sel all inactive; seg_out already shows
//    the new digit.
//  - Outputs registered: seg_out/dp_out/dig_sel reflect index/prescaler/display of previous
//    cycle (1-cycle latency). frame_start pulses the cycle dig_sel slot 0 begins (blank start).
//  - enable=0: prescaler and index hold, outputs inactive next cycle; enable=1 resumes the
//    current slot from the held prescaler value.
//  - Polarity inversions apply only at output registers; all internal logic is active-high.
//  - rst_n mid-scan: outputs go inactive immediately; no partial frame completes.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, polarity params 0 unless noted)
//  1 Reset: rst_n=0 mid-frame -> seg_out=0, dig_sel=0000, frame_start=0 with no clk edge.
//  2 Scan: load 16'h1234, dp=0 -> after boundary, per 4-cycle slot: 1 blank cycle then
//    dig_sel=0001 seg=1100110, 0010 seg=1001111, 0100 seg=1011011, 1000 seg=0000110; wraps.
//  3 Buffering: load 16'h5678 mid-frame -> current frame unchanged; next frame shows 5678;
//    load at boundary cycle -> shown in the frame starting that boundary.
//  4 Suppression: load 16'h0070 -> digits 3,2 seg=0000000, digit1 0000111, digit0 0111111;
//    dp_in=4'b0100 -> digit 2 shows 0111111 with dp_out=1.
//  5 Hex/invalid: load 16'h00AF: HEX_MODE=0 -> digits 1,0 blank; HEX_MODE=1 -> 1110111, 1110001.
//  6 Enable/polarity: enable=0 for 10 cycles -> dig_sel inactive, index frozen; DIG_ACTIVE_LOW=1
//    -> active digit 0 drives dig_sel=1110.

Source files
------------

// File: rtl/bcd_7seg_scan_driver.sv
// bcd_7seg_scan_driver
//   Time-multiplexed N-digit 7-segment display driver. Packed BCD digits and
//   decimal points are captured into a pending buffer and promoted to the
//   display buffer at frame boundaries. One digit is lit per scan slot, with a
//   dark interval at the start of each slot to avoid ghosting.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       0: display dark, scan position held
//   load         capture digits_in / dp_in this cycle
//   digits_in    packed BCD, [3:0] = digit 0 (rightmost)
//   dp_in        decimal point per digit
//   seg_out      segments {g,f,e,d,c,b,a}, bit 0 = a
//   dp_out       decimal point of the active digit
//   dig_sel      one-hot digit enable
//   frame_start  one-cycle pulse when the digit 0 slot begins
module bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int HEX_MODE       = 0,
  parameter int LZ_SUPPRESS    = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  logic [PW-1:0]             presc_p0;
  logic [IW-1:0]             idx_p0;
  logic [4*NUM_DIGITS-1:0]   disp_digits_p0;
  logic [NUM_DIGITS-1:0]     disp_dp_p0;
  logic [4*NUM_DIGITS-1:0]   pend_digits;
  logic [NUM_DIGITS-1:0]     pend_dp;
  logic                      pend_valid;

  logic                      slot_wrap;
  logic                      frame_bnd;
  logic [NUM_DIGITS-1:0]     lz_blank;
  logic                      lz_run;
  logic [3:0]                cur_code;
  logic [6:0]                seg_p0;
  logic                      dp_p0;
  logic [NUM_DIGITS-1:0]     dig_p0;
  logic                      vld_p0;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic hex;
    hex = (HEX_MODE != 0);
    case (code)
      4'h0: seg_decode = 7'b0111111;
      4'h1: seg_decode = 7'b0000110;
      4'h2: seg_decode = 7'b1011011;
      4'h3: seg_decode = 7'b1001111;
      4'h4: seg_decode = 7'b1100110;
      4'h5: seg_decode = 7'b1101101;
      4'h6: seg_decode = 7'b1111101;
      4'h7: seg_decode = 7'b0000111;
      4'h8: seg_decode = 7'b1111111;
      4'h9: seg_decode = 7'b1101111;
      4'hA: seg_decode = hex ? 7'b1110111 : 7'b0000000;
      4'hB: seg_decode = hex ? 7'b1111100 : 7'b0000000;
      4'hC: seg_decode = hex ? 7'b0111001 : 7'b0000000;
      4'hD: seg_decode = hex ? 7'b1011110 : 7'b0000000;
      4'hE: seg_decode = hex ? 7'b1111001 : 7'b0000000;
      default: seg_decode = hex ? 7'b1110001 : 7'b0000000;
    endcase
  endfunction

  assign slot_wrap = (presc_p0 == PRESC_LAST);
  assign frame_bnd = enable && slot_wrap && (idx_p0 == IDX_LAST);

  // Scan position: prescaler within the slot, digit index within the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_p0 <= '0;
      idx_p0   <= '0;
    end else if (enable) begin
      if (slot_wrap) begin
        presc_p0 <= '0;
        idx_p0   <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end else begin
        presc_p0 <= presc_p0 + 1'b1;
      end
    end
  end

  // Double buffer. A load on the boundary cycle bypasses pending so it is
  // shown in the frame that begins at that boundary. While disabled there is
  // no frame boundary, so pending is promoted on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits    <= '0;
      pend_dp        <= '0;
      pend_valid     <= 1'b0;
      disp_digits_p0 <= '0;
      disp_dp_p0     <= '0;
    end else if (load && frame_bnd) begin
      pend_digits    <= digits_in;
      pend_dp        <= dp_in;
      pend_valid     <= 1'b0;
      disp_digits_p0 <= digits_in;
      disp_dp_p0     <= dp_in;
    end else begin
      if ((frame_bnd || !enable) && pend_valid) begin
        disp_digits_p0 <= pend_digits;
        disp_dp_p0     <= pend_dp;
        pend_valid     <= 1'b0;
      end
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_valid  <= 1'b1;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while digits are zero
  // with no decimal point; digit 0 is always shown.
  always_comb begin
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run & (disp_digits_p0[4*k +: 4] == 4'd0) & ~disp_dp_p0[k];
      if (k != 0 && LZ_SUPPRESS != 0) lz_blank[k] = lz_run;
    end
  end

  assign vld_p0   = enable;
  assign cur_code = disp_digits_p0[{idx_p0, 2'b00} +: 4];
  assign seg_p0   = (vld_p0 && !lz_blank[idx_p0]) ? seg_decode(cur_code) : 7'b0000000;
  assign dp_p0    = vld_p0 & disp_dp_p0[idx_p0];
  assign dig_p0   = (vld_p0 && !(int'(presc_p0) < BLANK_CYCLES))
                    ? (NUM_DIGITS'(1) << idx_p0) : '0;

  // Output stage: pin polarity is applied only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out     <= {7{SEG_INV}};
      dp_out      <= SEG_INV;
      dig_sel     <= {NUM_DIGITS{DIG_INV}};
      frame_start <= 1'b0;
    end else begin
      seg_out     <= seg_p0 ^ {7{SEG_INV}};
      dp_out      <= dp_p0 ^ SEG_INV;
      dig_sel     <= dig_p0 ^ {NUM_DIGITS{DIG_INV}};
      frame_start <= vld_p0 && (presc_p0 == '0) && (idx_p0 == '0);
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Bench for bcd_7seg_scan_driver: two instances share stimulus, one with
// decimal-only decode and active-high pins, one with hex decode and both
// pin groups active-low. A frame-position reference model predicts both.
module tb_bcd_7seg_scan_driver;
  localparam int S = 4;
  localparam int N = 4;
  localparam int B = 1;
  localparam logic [12:0] INV1 = 13'h1FFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0;
  logic [6:0] seg0, seg1;
  logic dp0, dp1, fs0, fs1;
  logic [3:0] dig0, dig1;
  logic [12:0] obs0, obs1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_7seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B), .HEX_MODE(0),
    .LZ_SUPPRESS(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .seg_out(seg0), .dp_out(dp0), .dig_sel(dig0), .frame_start(fs0));

  bcd_7seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B), .HEX_MODE(1),
    .LZ_SUPPRESS(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .seg_out(seg1), .dp_out(dp1), .dig_sel(dig1), .frame_start(fs1));

  assign obs0 = {seg0, dp0, dig0, fs0};
  assign obs1 = {seg1, dp1, dig1, fs1};

  // ---------------- reference model ----------------
  logic [6:0] dec_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
  int m_t = 0;
  logic [15:0] m_shown = '0, m_pend = '0;
  logic [3:0] m_sdp = '0, m_pdp = '0;
  bit m_pv = 0;
  bit m_bnd;
  logic [12:0] exp0 = '0;
  logic [12:0] exp1 = INV1;

  // Logical {seg, dp, dig, fs} seen when the frame position is t.
  function automatic logic [12:0] model_out(input bit en, input int t, input logic [15:0] shown,
                                            input logic [3:0] sdp, input bit hex);
    int slot, pos;
    logic [3:0] code;
    bit blank;
    logic [6:0] seg;
    logic [3:0] dig;
    if (!en) return '0;
    slot = t / S;
    pos = t % S;
    code = shown[slot*4 +: 4];
    blank = (slot > 0);
    for (int j = slot; j < N; j++)
      if (shown[j*4 +: 4] != 4'd0 || sdp[j]) blank = 0;
    if (blank) seg = '0;
    else if (code < 4'd10 || hex) seg = dec_tab[code];
    else seg = '0;
    dig = (pos < B) ? 4'b0000 : 4'(1 << slot);
    return {seg, sdp[slot], dig, (t == 0)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_shown = '0; m_sdp = '0; m_pend = '0; m_pdp = '0; m_pv = 0;
      exp0 = '0; exp1 = INV1;
    end else begin
      exp0 = model_out(enable, m_t, m_shown, m_sdp, 0);
      exp1 = model_out(enable, m_t, m_shown, m_sdp, 1) ^ INV1;
      m_bnd = enable && (m_t == S*N - 1);
      if (load && m_bnd) begin
        m_shown = digits_in; m_sdp = dp_in; m_pv = 0;
      end else begin
        if ((m_bnd || !enable) && m_pv) begin m_shown = m_pend; m_sdp = m_pdp; m_pv = 0; end
        if (load) begin m_pend = digits_in; m_pdp = dp_in; m_pv = 1; end
      end
      if (enable) m_t = (m_t + 1) % (S*N);
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (obs0 !== 13'h0000 || obs1 !== INV1) begin
        n_fail++; $display("FAIL reset_hold dut0=%h dut1=%h required %h/%h", obs0, obs1, 13'h0, INV1);
      end
    end
    rst_n = 1'b1; load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0001;
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(negedge clk);
      load = 1'b0;
      n_chk++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("FAIL reset_run t=%0t dut0=%h exp0=%h dut1=%h exp1=%h", $time, obs0, exp0, obs1, exp1);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs0 !== 13'h0000 || obs1 !== INV1) begin
      n_fail++; $display("FAIL reset_async dut0=%h dut1=%h required %h/%h", obs0, obs1, 13'h0, INV1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [6:0] tab [4] = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
    int base = -1;
    int i, k, c;
    logic [3:0] edig;
    enable = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      n_chk++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("FAIL scan_model t=%0t dut0=%h exp0=%h dut1=%h exp1=%h", $time, obs0, exp0, obs1, exp1);
      end
      if (base < 0 && cyc >= 2 && fs0 === 1'b1) base = cyc;
      if (base >= 0 && cyc - base < 32) begin
        i = cyc - base; k = (i / 4) % 4; c = i % 4;
        edig = (c == 0) ? 4'b0000 : 4'(1 << k);
        n_chk++;
        if (seg0 !== tab[k] || dig0 !== edig || fs0 !== (i % 16 == 0)) begin
          n_fail++; $display("FAIL scan_pattern i=%0d seg=%b dig=%b fs=%b required seg=%b dig=%b", i, seg0, dig0, fs0, tab[k], edig);
        end
        if (k == 0 && c != 0) begin
          n_chk++;
          if (dig1 !== 4'b1110) begin
            n_fail++; $display("FAIL scan_dig_active_low i=%0d dig_sel=%b required 1110", i, dig1);
          end
        end
      end
      load = (cyc == 0);
      if (cyc == 0) begin digits_in = 16'h1234; dp_in = 4'b0000; end
    end
    n_chk++;
    if (base < 0) begin n_fail++; $display("FAIL scan_frame_start seen=0 required=1"); end
  endtask

  task automatic test_buffering();
    logic [6:0] tab [12] = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110,
                             7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
                             7'b1011011, 7'b0000110, 7'b0111111, 7'b1101111};
    int base = -1;
    int i, k;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      n_chk++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("FAIL buf_model t=%0t dut0=%h exp0=%h dut1=%h exp1=%h", $time, obs0, exp0, obs1, exp1);
      end
      if (base < 0 && fs0 === 1'b1) base = cyc;
      i = (base >= 0) ? cyc - base : -1;
      if (i >= 0 && i < 48) begin
        k = (i / 4) % 4;
        n_chk++;
        if (seg0 !== tab[(i / 16) * 4 + k]) begin
          n_fail++; $display("FAIL buf_frame i=%0d seg=%b required %b", i, seg0, tab[(i / 16) * 4 + k]);
        end
      end
      load = (i == 5 || i == 8 || i == 30);
      if (i == 5) digits_in = 16'h4321;
      if (i == 8) digits_in = 16'h5678;
      if (i == 30) digits_in = 16'h9012;
      dp_in = 4'b0000;
    end
    n_chk++;
    if (base < 0) begin n_fail++; $display("FAIL buf_frame_start seen=0 required=1"); end
  endtask

  task automatic test_suppress();
    logic [6:0] tab [8] = '{7'b0111111, 7'b0000111, 7'b0000000, 7'b0000000,
                            7'b0111111, 7'b0000111, 7'b0111111, 7'b0000000};
    int base = -1;
    int i, k, f;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      n_chk++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("FAIL lz_model t=%0t dut0=%h exp0=%h dut1=%h exp1=%h", $time, obs0, exp0, obs1, exp1);
      end
      if (base < 0 && cyc >= 2 && fs0 === 1'b1) base = cyc;
      i = (base >= 0) ? cyc - base : -1;
      if (i >= 0 && i < 32) begin
        k = (i / 4) % 4; f = i / 16;
        n_chk++;
        if (seg0 !== tab[f*4 + k] || dp0 !== (f == 1 && k == 2)) begin
          n_fail++; $display("FAIL lz_digit i=%0d seg=%b dp=%b required seg=%b dp=%b", i, seg0, dp0, tab[f*4 + k], (f == 1 && k == 2));
        end
      end
      load = (cyc == 0 || i == 5);
      digits_in = 16'h0070;
      dp_in = (i >= 5) ? 4'b0100 : 4'b0000;
    end
    n_chk++;
    if (base < 0) begin n_fail++; $display("FAIL lz_frame_start seen=0 required=1"); end
  endtask

  task automatic test_hex();
    logic [6:0] tab [4] = '{7'b1110001, 7'b1110111, 7'b0000000, 7'b0000000};
    int base = -1;
    int i, k;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      n_chk++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("FAIL hex_model t=%0t dut0=%h exp0=%h dut1=%h exp1=%h", $time, obs0, exp0, obs1, exp1);
      end
      if (base < 0 && cyc >= 2 && fs0 === 1'b1) base = cyc;
      i = (base >= 0) ? cyc - base : -1;
      if (i >= 0 && i < 16) begin
        k = i / 4;
        n_chk++;
        if (seg0 !== 7'b0000000 || seg1 !== ~tab[k]) begin
          n_fail++; $display("FAIL hex_digit i=%0d seg_dec=%b seg_hex=%b required 0000000/%b", i, seg0, seg1, ~tab[k]);
        end
      end
      load = (cyc == 0);
      digits_in = 16'h00AF; dp_in = 4'b0000;
    end
    n_chk++;
    if (base < 0) begin n_fail++; $display("FAIL hex_frame_start seen=0 required=1"); end
  endtask

  task automatic test_enable();
    logic [6:0] tab [4] = '{7'b1111111, 7'b1111101, 7'b1100110, 7'b1011011};
    int base = -1;
    int i, t;
    logic [3:0] edig;
    for (int cyc = 0; cyc < 62; cyc++) begin
      @(negedge clk);
      n_chk++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("FAIL en_model t=%0t dut0=%h exp0=%h dut1=%h exp1=%h", $time, obs0, exp0, obs1, exp1);
      end
      if (base < 0 && cyc >= 2 && fs0 === 1'b1) base = cyc;
      i = (base >= 0) ? cyc - base : -1;
      if (i >= 6 && i < 16) begin
        n_chk++;
        if (seg0 !== 7'b0 || dig0 !== 4'b0 || dig1 !== 4'hF || fs0 !== 1'b0) begin
          n_fail++; $display("FAIL en_dark i=%0d seg=%b dig=%b dig_low=%b required 0000000/0000/1111", i, seg0, dig0, dig1);
        end
      end else if (i >= 0 && i < 36) begin
        t = (i < 6) ? i : (i - 10) % 16;
        edig = (t % 4 == 0) ? 4'b0000 : 4'(1 << (t / 4));
        n_chk++;
        if (seg0 !== tab[t / 4] || dig0 !== edig || fs0 !== (t == 0)) begin
          n_fail++; $display("FAIL en_resume i=%0d seg=%b dig=%b fs=%b required seg=%b dig=%b fs=%b", i, seg0, dig0, fs0, tab[t / 4], edig, (t == 0));
        end
      end
      load = (cyc == 0);
      digits_in = 16'h2468; dp_in = 4'b0000;
      if (i == 5) enable = 1'b0;
      if (i == 15) enable = 1'b1;
    end
    enable = 1'b1;
    n_chk++;
    if (base < 0) begin n_fail++; $display("FAIL en_frame_start seen=0 required=1"); end
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      n_chk++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("FAIL rand_model t=%0t dut0=%h exp0=%h dut1=%h exp1=%h", $time, obs0, exp0, obs1, exp1);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      enable = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 11) == 0);
      for (int n = 0; n < 4; n++)
        d[n*4 +: 4] = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
      digits_in = d;
      dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
    end
    rst_n = 1'b1; enable = 1'b1; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_buffering();
    test_suppress();
    test_hex();
    test_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
